// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern modes, bar colour table and
// the default 640x480 timing.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_BORDER = 2'd3
  } mode_t;

  localparam int DEF_DIV      = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

  // {R,G,B} for bars 0..7, left to right
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] c;
    c = 3'b000;
    case (idx)
      3'd0: c = 3'b111;
      3'd1: c = 3'b110;
      3'd2: c = 3'b011;
      3'd3: c = 3'b010;
      3'd4: c = 3'b101;
      3'd5: c = 3'b100;
      3'd6: c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/controlador_vga_param_core.sv
// Pixel divider, h/v raster counters and sync/active decode
// of the current counter position.
module vga_timing_core #(
  parameter int DIV      = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_active
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]    r_div;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Held low in reset so DIV=1 does not show a tick there
  assign o_tick   = w_tick & ~i_rst;
  assign o_h_cnt  = r_h;
  assign o_v_cnt  = r_v;
  assign o_hs     = (r_h >= H_SS) && (r_h < H_SE);
  assign o_vs     = (r_v >= V_SS) && (r_v < V_SE);
  assign o_active = (r_h < H_ACT) && (r_v < V_ACT);

endmodule

// File: rtl/controlador_vga_param.sv
// Parametrised VGA controller: timing core, frame-synchronous
// pattern select and registered sync/RGB/coordinate outputs.
module controlador_vga_param
  import vga_pkg::*;
#(
  parameter int DIV      = DEF_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 1,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CHK_LOG2 = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [2:0]           ctrl_rgb,
  input  logic [1:0]           mode,
  output logic [3*COLOR_W-1:0] graph_rgb,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 video_on,
  output logic [CNT_W-1:0]     pixel_x,
  output logic [CNT_W-1:0]     pixel_y,
  output logic                 p_tick,
  output logic                 frame_start
);

  localparam int RGB_W = 3 * COLOR_W;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_RIGHT = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_BOT   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BAR_END = CNT_W'(H_ACTIVE / 8 - 1);

  logic             w_tick;
  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_hs;
  logic             w_vs;
  logic             w_active;
  logic             w_origin;
  mode_t            w_mode;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_bar_px;
  logic [3:0]       r_bar_idx;
  logic [2:0]       w_pat;
  logic [RGB_W-1:0] w_rgb;

  vga_timing_core #(
    .DIV(DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .H_SYNC(H_SYNC), .H_BP(H_BP), .V_ACTIVE(V_ACTIVE),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W(CNT_W)
  ) u_core (
    .i_clk(CLK),
    .i_rst(RESET),
    .o_tick(w_tick),
    .o_h_cnt(w_h),
    .o_v_cnt(w_v),
    .o_hs(w_hs),
    .o_vs(w_vs),
    .o_active(w_active)
  );

  assign w_origin = (w_h == '0) && (w_v == '0);
  // New mode already applies to the pixel that starts the frame
  assign w_mode   = w_origin ? mode_t'(mode) : r_mode;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                   r_mode <= MODE_SOLID;
    else if (w_tick && w_origin) r_mode <= mode_t'(mode);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bar_px  <= '0;
      r_bar_idx <= '0;
    end else if (w_tick) begin
      if (w_h == H_LAST) begin
        r_bar_px  <= '0;
        r_bar_idx <= '0;
      end else if (w_h < H_ACT) begin
        if (r_bar_px == BAR_END) begin
          r_bar_px <= '0;
          if (!r_bar_idx[3]) r_bar_idx <= r_bar_idx + 1'b1;
        end else begin
          r_bar_px <= r_bar_px + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_pat = 3'b000;
    unique case (w_mode)
      MODE_SOLID:  w_pat = ctrl_rgb;
      MODE_BARS:
        w_pat = r_bar_idx[3] ? 3'b000 : bar_rgb(r_bar_idx[2:0]);
      MODE_CHECK:
        w_pat = (w_h[CHK_LOG2] ^ w_v[CHK_LOG2]) ? ctrl_rgb : 3'b000;
      MODE_BORDER:
        w_pat = (w_v == '0 || w_v == V_BOT ||
                 w_h == '0 || w_h == H_RIGHT) ? ctrl_rgb : 3'b000;
    endcase
    w_rgb = '0;
    if (w_active)
      w_rgb = {{COLOR_W{w_pat[2]}}, {COLOR_W{w_pat[1]}},
               {COLOR_W{w_pat[0]}}};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      graph_rgb   <= '0;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else if (w_tick) begin
      graph_rgb   <= w_rgb;
      h_sync      <= w_hs ? SYNC_POL : ~SYNC_POL;
      v_sync      <= w_vs ? SYNC_POL : ~SYNC_POL;
      video_on    <= w_active;
      pixel_x     <= w_h;
      pixel_y     <= w_v;
      frame_start <= w_origin;
    end
  end

  assign p_tick = w_tick;

endmodule

// File: tb/tb_controlador_vga_param.sv
// Directed bench: small 8x4 raster, 16-wide bars raster and
// the default 640x480 raster with DIV=3.
module tb_controlador_vga_param;

  logic       CLK;
  logic       RESET;
  logic [2:0] ctrl_rgb;
  logic [1:0] mode;

  logic [5:0] s_rgb;
  logic       s_hs, s_vs, s_von, s_tick, s_fs;
  logic [9:0] s_px, s_py;

  logic [5:0] b_rgb;
  logic       b_hs, b_vs, b_von, b_tick, b_fs;
  logic [9:0] b_px, b_py;

  logic [2:0] d_rgb;
  logic       d_hs, d_vs, d_von, d_tick, d_fs;
  logic [9:0] d_px, d_py;

  int checks   = 0;
  int failures = 0;

  controlador_vga_param #(
    .DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .COLOR_W(2), .CNT_W(10), .CHK_LOG2(1)
  ) s (
    .CLK(CLK), .RESET(RESET), .ctrl_rgb(ctrl_rgb), .mode(mode),
    .graph_rgb(s_rgb), .h_sync(s_hs), .v_sync(s_vs),
    .video_on(s_von), .pixel_x(s_px), .pixel_y(s_py),
    .p_tick(s_tick), .frame_start(s_fs)
  );

  controlador_vga_param #(
    .DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .COLOR_W(2), .CNT_W(10), .CHK_LOG2(1)
  ) b (
    .CLK(CLK), .RESET(RESET), .ctrl_rgb(ctrl_rgb), .mode(mode),
    .graph_rgb(b_rgb), .h_sync(b_hs), .v_sync(b_vs),
    .video_on(b_von), .pixel_x(b_px), .pixel_y(b_py),
    .p_tick(b_tick), .frame_start(b_fs)
  );

  controlador_vga_param #(
    .DIV(3)
  ) d (
    .CLK(CLK), .RESET(RESET), .ctrl_rgb(ctrl_rgb), .mode(mode),
    .graph_rgb(d_rgb), .h_sync(d_hs), .v_sync(d_vs),
    .video_on(d_von), .pixel_x(d_px), .pixel_y(d_py),
    .p_tick(d_tick), .frame_start(d_fs)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stp(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_fs(input int inst, output int n);
    n = 0;
    do begin
      stp(1);
      n++;
    end while (!(inst == 0 ? s_fs : b_fs) && n < 300);
    chk("wait_fs", inst == 0 ? s_fs : b_fs, 1);
  endtask

  int         n;
  int         x, y;
  int         clks, hs_low, ticks, first_x;
  logic       on;
  logic [28:0] e;

  initial begin
    RESET    = 1'b1;
    mode     = 2'd0;
    ctrl_rgb = 3'b101;
    stp(3);
    chk("rst_rgb", s_rgb, 0);
    chk("rst_hs", s_hs, 1);
    chk("rst_vs", s_vs, 1);
    chk("rst_von", s_von, 0);
    chk("rst_xy", {s_px, s_py}, 0);
    chk("rst_tick", s_tick, 0);
    chk("rst_fs", s_fs, 0);
    chk("rst_d_tick", d_tick, 0);

    @(negedge CLK);
    RESET = 1'b0;
    stp(1);
    chk("first_xy", {s_px, s_py}, 0);
    chk("first_fs", s_fs, 1);
    chk("first_rgb", s_rgb, 6'h33);
    chk("first_von", s_von, 1);
    chk("first_tick", s_tick, 1);
    wait_fs(0, n);
    chk("fs_period", n, 112);

    for (int i = 0; i < 112; i++) begin
      x  = i % 14;
      y  = i / 14;
      on = (x < 8) && (y < 4);
      e  = {(on ? 6'h33 : 6'h00), on,
            !(x >= 10 && x <= 12), !(y == 5 || y == 6),
            10'(x), 10'(y)};
      chk("scan", {s_rgb, s_von, s_hs, s_vs, s_px, s_py}, 32'(e));
      stp(1);
    end
    chk("scan_wrap_fs", s_fs, 1);

    mode = 2'd1;
    wait_fs(0, n);
    chk("sbar_x0", s_rgb, 6'h3F);
    stp(1);
    chk("sbar_x1", s_rgb, 6'h3C);
    stp(1);
    chk("sbar_x2", s_rgb, 6'h0F);
    wait_fs(1, n);
    chk("bar_x0", b_rgb, 6'h3F);
    stp(1);
    chk("bar_x1", b_rgb, 6'h3F);
    stp(1);
    chk("bar_x2", b_rgb, 6'h3C);
    stp(10);
    chk("bar_x12", b_rgb, 6'h03);
    stp(2);
    chk("bar_x14", {b_px, b_rgb}, {10'd14, 6'h00});
    stp(1);
    chk("bar_x15", {b_px, b_rgb}, {10'd15, 6'h00});

    mode     = 2'd2;
    ctrl_rgb = 3'b111;
    wait_fs(0, n);
    chk("chk_0_0", s_rgb, 6'h00);
    stp(2);
    chk("chk_2_0", s_rgb, 6'h3F);
    stp(28);
    chk("chk_2_2", {s_px, s_py, s_rgb}, {10'd2, 10'd2, 6'h00});
    stp(12);
    chk("chk_0_3", {s_px, s_py, s_rgb}, {10'd0, 10'd3, 6'h3F});

    mode = 2'd0;
    wait_fs(0, n);
    stp(17);
    mode = 2'd3;
    stp(1);
    chk("mid_4_1", {s_px, s_py, s_rgb}, {10'd4, 10'd1, 6'h3F});
    stp(15);
    chk("mid_5_2", {s_px, s_py, s_rgb}, {10'd5, 10'd2, 6'h3F});
    wait_fs(0, n);
    chk("mid_to_fs", n, 79);
    chk("brd_0_0", s_rgb, 6'h3F);
    stp(15);
    chk("brd_1_1", {s_px, s_py, s_rgb}, {10'd1, 10'd1, 6'h00});
    stp(6);
    chk("brd_7_1", {s_px, s_py, s_rgb}, {10'd7, 10'd1, 6'h3F});

    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    stp(1);
    chk("d_tick_c1", d_tick, 0);
    chk("s_restart_fs", {s_fs, s_px, s_py}, {1'b1, 20'd0});
    stp(1);
    chk("d_tick_c2", d_tick, 1);
    stp(1);
    chk("d_tick_c3", d_tick, 0);
    chk("d_first", {d_fs, d_px, d_py}, {1'b1, 20'd0});
    chk("d_first_rgb", d_rgb, 3'h7);

    clks    = 0;
    hs_low  = 0;
    ticks   = 0;
    first_x = -1;
    do begin
      stp(1);
      clks++;
      if (d_tick) ticks++;
      if (!d_hs) begin
        hs_low++;
        if (first_x < 0) first_x = int'(d_px);
      end
    end while (d_py != 10'd1 && clks < 3000);
    chk("d_line_clks", clks, 2400);
    chk("d_line_ticks", ticks, 800);
    chk("d_hs_clks", hs_low, 288);
    chk("d_hs_start", first_x, 656);

    clks = 0;
    do begin
      stp(1);
      clks++;
    end while (!(d_py == 10'd2 && d_px == 10'd100) && clks < 6000);
    chk("d_reach", {d_px, d_py}, {10'd100, 10'd2});
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("d_mid_rst", {d_px, d_py, d_hs, d_rgb}, {20'd0, 1'b1, 3'd0});
    RESET = 1'b0;
    stp(3);
    chk("d_restart", {d_fs, d_px, d_py}, {1'b1, 20'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
